// File: rtl/polirv_mem_responder_if.sv
// Loader byte stream and instruction-fetch bus between the polirv core side and the responder.
interface polirv_mem_responder_if #(
  parameter int i_addr_bits = 6
);
  logic                   ld_valid;
  logic [7:0]             ld_byte;
  logic                   ld_last;
  logic                   ld_ready;
  logic                   ld_done;
  logic                   core_rst_n;
  logic [i_addr_bits-1:0] i_mem_addr;
  logic [31:0]            i_mem_data;

  modport master (
    output ld_valid, ld_byte, ld_last, i_mem_addr,
    input  ld_ready, ld_done, core_rst_n, i_mem_data
  );
  modport slave (
    input  ld_valid, ld_byte, ld_last, i_mem_addr,
    output ld_ready, ld_done, core_rst_n, i_mem_data
  );
endinterface

// File: rtl/polirv_mem_responder.sv
// Memory responder for polirv: boot-loads imem from a byte stream, then serves
// instruction fetches and 64-bit data loads/stores while releasing the core reset.
module polirv_mem_responder #(
  parameter int i_addr_bits = 6,
  parameter int d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  polirv_mem_responder_if.slave  bus,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data
);
  localparam int WPW = i_addr_bits - 2;
  localparam int NW  = 1 << WPW;
  localparam logic [WPW-1:0] LAST_W = '1;
  localparam logic [WPW-1:0] ONE_W  = 1;
  localparam logic [WPW:0]   ONE_C  = 1;
  localparam logic [31:0]    NOP    = 32'h0000_0013;

  typedef enum logic {LOAD, RUN} state_t;

  state_t         state_q, state_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [WPW-1:0] word_ptr_q, word_ptr_d;
  logic [WPW:0]   word_cnt_q, word_cnt_d;
  logic [31:0]    asm_q, asm_d, asm_nxt;
  logic           core_rst_n_q;
  logic           accept, commit;

  logic [31:0] imem [NW];
  logic [63:0] dmem [1 << d_addr_bits];

  assign bus.ld_ready   = (state_q == LOAD);
  assign bus.ld_done    = (state_q == RUN);
  assign bus.core_rst_n = core_rst_n_q;

  assign accept  = bus.ld_valid && bus.ld_ready;
  assign asm_nxt = asm_q | (32'(bus.ld_byte) << {byte_idx_q, 3'b000});
  assign commit  = accept && (byte_idx_q == 2'd3 || bus.ld_last);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_ptr_d = word_ptr_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    if (commit) begin
      byte_idx_d = 2'd0;
      asm_d      = 32'd0;
      word_ptr_d = word_ptr_q + ONE_W;
      word_cnt_d = {1'b0, word_ptr_q} + ONE_C;
      // ld_last and the final address collapse into the same single exit
      if (bus.ld_last || word_ptr_q == LAST_W) state_d = RUN;
    end else if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      asm_d      = asm_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      byte_idx_q   <= 2'd0;
      word_ptr_q   <= '0;
      word_cnt_q   <= '0;
      asm_q        <= 32'd0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_ptr_q   <= word_ptr_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      core_rst_n_q <= (state_q == RUN);
    end
  end

  // Arrays are deliberately unreset so contents survive rst
  always_ff @(posedge clk) begin
    if (commit) imem[word_ptr_q] <= asm_nxt;
    if (state_q == RUN && d_mem_we) dmem[d_mem_addr] <= d_mem_data;
  end

  logic [WPW-1:0] widx;
  logic [1:0]     unused_addr_lsb;
  assign widx            = bus.i_mem_addr[i_addr_bits-1:2];
  assign unused_addr_lsb = bus.i_mem_addr[1:0];
  assign bus.i_mem_data  = ({1'b0, widx} < word_cnt_q) ? imem[widx] : NOP;

  assign d_mem_data = (state_q == RUN && !d_mem_we) ? dmem[d_mem_addr] : 64'bz;
endmodule

// File: tb/tb_polirv_mem_responder.sv
// Bench for polirv_mem_responder: fetch tables, loader sequences and data-bus traffic.
module tb_polirv_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        d_mem_we = 1'b0;
  logic [5:0]  d_mem_addr = '0;
  logic        core_drv = 1'b0;
  logic [63:0] core_val = '0;
  wire  [63:0] d_bus;

  polirv_mem_responder_if #(.i_addr_bits(6)) bus();

  polirv_mem_responder #(.i_addr_bits(6), .d_addr_bits(6)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_bus)
  );

  assign d_bus = core_drv ? core_val : 64'bz;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { string nm; logic [63:0] exp; } sb_t;
  sb_t sbq[$];

  typedef struct { logic [5:0] addr; logic [31:0] exp; } fv_t;
  fv_t tbl[5];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] VAL_A = 64'hA5A5_5A5A_1122_3344;
  localparam logic [63:0] VAL_B = 64'h0123_4567_89AB_CDEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [63:0] e);
    sb_t s;
    s.nm = nm; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic sb_pop(input logic [63:0] act);
    sb_t s;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      s = sbq.pop_front();
      chk(s.nm, act, s.exp);
    end
  endtask

  task automatic fetch(input string nm, input logic [5:0] a, input logic [31:0] e);
    bus.i_mem_addr = a;
    sb_push(nm, {32'd0, e});
    #1;
    sb_pop({32'd0, bus.i_mem_data});
  endtask

  task automatic dload(input string nm, input logic [5:0] a, input logic [63:0] e);
    d_mem_we = 1'b0; core_drv = 1'b0; d_mem_addr = a;
    sb_push(nm, e);
    #1;
    sb_pop(d_bus);
  endtask

  task automatic send(input logic [7:0] b, input bit last, input int gap);
    bus.ld_valid = 1'b1; bus.ld_byte = b; bus.ld_last = last;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    #3 rst = 1'b1;
    #1;
    chk("rst_ld_ready", {63'd0, bus.ld_ready}, 64'd1);
    chk("rst_core_rst_n", {63'd0, bus.core_rst_n}, 64'd0);
    chk("rst_ld_done", {63'd0, bus.ld_done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] img [8];
    img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    tbl[0] = '{6'd0,  32'h0010_0513};
    tbl[1] = '{6'd4,  32'h0020_0593};
    tbl[2] = '{6'd8,  NOP};
    tbl[3] = '{6'd6,  32'h0020_0593};
    tbl[4] = '{6'd2,  32'h0010_0513};

    bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0; bus.i_mem_addr = '0;
    #2;
    chk("reset_ld_ready", {63'd0, bus.ld_ready}, 64'd1);
    chk("reset_ld_done", {63'd0, bus.ld_done}, 64'd0);
    chk("reset_core_rst_n", {63'd0, bus.core_rst_n}, 64'd0);
    fetch("reset_fetch0", 6'd0, NOP);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // full-word load, back-to-back
    for (int i = 0; i < 8; i++) send(img[i], i == 7, 0);
    chk("full_ld_done", {63'd0, bus.ld_done}, 64'd1);
    chk("full_ld_ready", {63'd0, bus.ld_ready}, 64'd0);
    chk("full_core_rst_n_lag", {63'd0, bus.core_rst_n}, 64'd0);
    @(posedge clk); #1;
    chk("full_core_rst_n", {63'd0, bus.core_rst_n}, 64'd1);
    for (int i = 0; i < 5; i++) fetch($sformatf("full_fetch_%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);

    // data bus: store A@4, B@3, then read back
    d_mem_we = 1'b1; core_drv = 1'b1; d_mem_addr = 6'd4; core_val = VAL_A;
    @(posedge clk); #1;
    d_mem_addr = 6'd3; core_val = VAL_B;
    #1 chk("store_bus_no_contention", d_bus, VAL_B);
    @(posedge clk); #1;
    dload("load_addr3", 6'd3, VAL_B);
    dload("load_addr4", 6'd4, VAL_A);

    // throttled reload of the same image
    pulse_rst();
    fetch("retain_fetch0_nop", 6'd0, NOP);
    for (int i = 0; i < 8; i++) send(img[i], i == 7, $urandom_range(1, 3));
    chk("thr_ld_done", {63'd0, bus.ld_done}, 64'd1);
    for (int i = 0; i < 5; i++) fetch($sformatf("thr_fetch_%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);

    // partial-word load with a store attempted during LOAD
    pulse_rst();
    d_mem_we = 1'b1; core_drv = 1'b1; d_mem_addr = 6'd4; core_val = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    d_mem_we = 1'b0; core_drv = 1'b0;
    send(8'hAA, 0, 1); send(8'hBB, 0, 2); send(8'hCC, 0, 3);
    send(8'hDD, 0, 1); send(8'hEE, 0, 2); send(8'hFF, 1, 0);
    chk("part_ld_done", {63'd0, bus.ld_done}, 64'd1);
    fetch("part_word0", 6'd0, 32'hDDCC_BBAA);
    fetch("part_word1", 6'd4, 32'h0000_FFEE);
    fetch("part_fetch8_nop", 6'd8, NOP);
    dload("load_store_ignored_in_load", 6'd4, VAL_A);

    // reset mid-load
    pulse_rst();
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0); send(8'h55, 0, 0);
    fetch("mid_word0_before_rst", 6'd0, 32'h4433_2211);
    pulse_rst();
    fetch("mid_fetch0_nop", 6'd0, NOP);
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 1, 0);
    chk("mid_ld_done", {63'd0, bus.ld_done}, 64'd1);
    fetch("mid_new_word0", 6'd0, 32'h0403_0201);
    fetch("mid_fetch4_nop", 6'd4, NOP);

    // capacity full: 64 bytes, no ld_last
    pulse_rst();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("cap_ready_before_last", {63'd0, bus.ld_ready}, 64'd1);
      send(8'(i), 0, 0);
    end
    chk("cap_ld_done", {63'd0, bus.ld_done}, 64'd1);
    chk("cap_ld_ready", {63'd0, bus.ld_ready}, 64'd0);
    bus.ld_valid = 1'b1; bus.ld_byte = 8'hFF; bus.ld_last = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("cap_still_done", {63'd0, bus.ld_done}, 64'd1);
    for (int w = 0; w < 16; w++) begin
      logic [31:0] e;
      e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      fetch($sformatf("cap_word%0d", w), 6'(4*w), e);
    end

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/polirv_mem_responder.md
Name: polirv_mem_responder

Overview:
- Memory-side responder for the polirv core's two buses: serves instruction fetches on the i_mem interface and data loads/stores on the d_mem interface, including the bidirectional 64-bit data bus.
- Contains a boot-loader FSM that fills instruction memory from a byte stream.
- Holds the core in reset, through core_rst_n, until loading completes.
- Sits beside the core at system top level.

Parameters:
- i_addr_bits, 6: width of i_mem_addr (byte address); instruction capacity is 2^(i_addr_bits-2) words.
- d_addr_bits, 6: width of d_mem_addr (doubleword index); data capacity is 2^d_addr_bits x 64 bit.

Ports:
- clk  in  1  clock; rising edge active.
- rst  in  1  asynchronous reset, active-high.
- ld_valid  in  1  a loader byte is present.
- ld_byte  in  8  loader byte; little-endian within each instruction word.
- ld_last  in  1  final byte of the image; qualified by ld_valid.
- ld_ready  out  1  responder accepts a byte this cycle.
- ld_done  out  1  image loaded; responder is in RUN.
- core_rst_n  out  1  active-low reset to the core.
- i_mem_addr  in  i_addr_bits  fetch byte address from the core.
- i_mem_data  out  32  instruction word.
- d_mem_we  in  1  core store strobe.
- d_mem_addr  in  d_addr_bits  doubleword index.
- d_mem_data  inout  64  driven by the core on stores, by the responder on loads.

Behaviour:
- States: LOAD and RUN. rst forces LOAD asynchronously.
- Reset values: state=LOAD, byte_idx=0, word_ptr=0, word_cnt=0, assembly register=0, ld_ready=1, ld_done=0, core_rst_n=0.
- core_rst_n is cleared asynchronously together with rst.
- LOAD, byte accept:
  - A byte is accepted when ld_valid && ld_ready on a rising edge.
  - The byte is placed at bits [8*byte_idx+7 : 8*byte_idx] of the assembly word, then byte_idx increments.
  - Cycles with ld_valid=0 change nothing.
- LOAD, word commit:
  - When the byte accepted has byte_idx==3, or when ld_last is set on it, the assembled word is written to imem[word_ptr]. Byte lanes not yet received are written as zero.
  - On commit: word_ptr++, word_cnt=word_ptr+1, byte_idx=0, assembly register cleared.
- LOAD exits to RUN:
  - after committing a word on a byte that carried ld_last, or
  - after committing the word at the last address, 2^(i_addr_bits-2)-1. Bytes beyond capacity are never accepted.
- RUN:
  - ld_ready=0, ld_done=1.
  - core_rst_n goes to 1 on the first rising edge after RUN is entered (registered, 1-cycle delay).
  - RUN is left only by rst.
- Instruction read (combinational), widx = i_mem_addr[i_addr_bits-1:2]:
  - i_mem_data = imem[widx] if widx < word_cnt, else 32'h00000013 (NOP).
  - i_mem_addr[1:0] is ignored.
  - During LOAD, the value returned is defined by the same rule.
- Data store: in RUN, when d_mem_we=1, dmem[d_mem_addr] <= d_mem_data on the rising edge. Stores are ignored in LOAD.
- Data load: in RUN with d_mem_we=0, d_mem_data is driven combinationally with dmem[d_mem_addr]. Otherwise d_mem_data is high-Z. The responder never drives while d_mem_we=1.
- Array contents: imem and dmem are not reset and retain their contents across rst. Because word_cnt returns to 0 on rst, all fetches return NOP until a reload.
- Reset mid-load: any partial assembly is discarded, and loading restarts at word 0 with byte_idx 0.
- Simultaneous ld_last and capacity-full: a single commit and a single transition to RUN.

Test Plan:
- Full-word load:
  - Stimulus: bytes 13 05 10 00 93 05 20 00, ld_last on the 8th byte.
  - Required: imem[0]=0x00100513 and imem[1]=0x00200593; ld_done=1 on the edge after the last byte, core_rst_n=1 one edge later.
  - Fetches: i_mem_addr=4 returns 0x00200593, i_mem_addr=8 returns 0x00000013, i_mem_addr=6 returns 0x00200593.
- Partial-word load:
  - Stimulus: bytes AA BB CC DD EE FF, ld_last on FF.
  - Required: word0=0xDDCCBBAA, word1=0x0000FFEE, word_cnt=2; i_mem_addr=8 returns NOP.
- Capacity full:
  - Stimulus: 64 bytes at default parameters, no ld_last.
  - Required: RUN entered after the 64th byte; ld_ready=0; a 65th ld_valid is not accepted; no further state change.
- Data bus:
  - Store: in RUN, d_mem_we=1, addr=3, core drives 0x0123456789ABCDEF; the responder is high-Z that cycle.
  - Load: next cycle d_mem_we=0, addr=3; the bus reads 0x0123456789ABCDEF.
  - Check: addr=4 returns its prior value, with no corruption.
- Reset mid-load:
  - Stimulus: 5 bytes accepted, then a rst pulse between clock edges.
  - Required: core_rst_n=0 and ld_ready=1 immediately; fetch at address 0 returns NOP; a fresh 4-byte load with ld_last yields the new word0.
- Throttled stream: bytes separated by 1–3 idle ld_valid=0 cycles assemble identically to the back-to-back case.
